// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries decoded operands, PC, destination and
// control from decode to execute, with valid tracking, stall/flush hazard
// control and saturating stall/flush event counters. All state updates on
// the falling edge of clock.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  rd1,
    input  logic [DATA_W-1:0]  rd2,
    input  logic [DATA_W-1:0]  PC,
    input  logic [RADDR_W-1:0] rd,
    input  logic               brz,
    input  logic               brn,
    input  logic               j,
    input  logic               regw,
    input  logic               wai,
    input  logic               memw,
    input  logic               memr,
    input  logic               alusrc,
    input  logic [ALUOP_W-1:0] aluop,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_imm,
    output logic [DATA_W-1:0]  out_rd1,
    output logic [DATA_W-1:0]  out_rd2,
    output logic [DATA_W-1:0]  out_PC,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_brz,
    output logic               out_brn,
    output logic               out_j,
    output logic               out_regw,
    output logic               out_wai,
    output logic               out_memw,
    output logic               out_memr,
    output logic               out_alusrc,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int unsigned CTRL_W = 8 + ALUOP_W;
    localparam int unsigned DBUS_W = 4 * DATA_W + RADDR_W;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_in, ctrl_q, ctrl_d;
    logic [DBUS_W-1:0] data_in, data_q, data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    assign ctrl_in = {brz, brn, j, regw, wai, memw, memr, alusrc, aluop};
    assign data_in = {imm, rd1, rd2, PC, rd};

    // Next-state: flush beats stall beats load; reset is handled in the register.
    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            // Bubble: kill valid and control, keep stale data (don't-care).
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (!(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CntOne;
            end
        end else if (stall) begin
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CntOne;
            end
        end else begin
            valid_d = in_valid;
            data_d  = data_in;
            // Control only passes with a real instruction so bubbles have no side effects.
            ctrl_d  = in_valid ? ctrl_in : '0;
        end
    end

    // Stage register with synchronous reset, updated on the falling edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign {out_brz, out_brn, out_j, out_regw, out_wai, out_memw, out_memr, out_alusrc,
            out_aluop} = ctrl_q;
    assign {out_imm, out_rd1, out_rd2, out_PC, out_rd} = data_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg (CNT_W=4 so saturation is reachable):
// a directed vector table, hand sequences for counter saturation, and a
// randomized run checked against a rule-level reference model.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        rst, stl, fls, iv;
        logic [31:0] imm, rd1, rd2, pc;
        logic [5:0]  rd;
        logic        brz, brn, j, regw, wai, memw, memr, alusrc;
        logic [2:0]  aluop;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] imm, rd1, rd2, pc;
        logic [5:0]  rd;
        logic        brz, brn, j, regw, wai, memw, memr, alusrc;
        logic [2:0]  aluop;
        logic [3:0]  sc, fc;
    } obs_t;

    typedef struct {
        string name;
        stim_t s;
        obs_t  e;
    } vec_t;

    logic        clock = 1'b1;
    logic        reset, stall, flush, in_valid;
    logic [31:0] imm, rd1, rd2, PC;
    logic [5:0]  rd;
    logic        brz, brn, j, regw, wai, memw, memr, alusrc;
    logic [2:0]  aluop;
    logic        out_valid;
    logic [31:0] out_imm, out_rd1, out_rd2, out_PC;
    logic [5:0]  out_rd;
    logic        out_brz, out_brn, out_j, out_regw, out_wai, out_memw, out_memr, out_alusrc;
    logic [2:0]  out_aluop;
    logic [3:0]  stall_cnt, flush_cnt;

    int   nvec = 0;
    int   errors = 0;
    vec_t tbl[$];
    obs_t m;          // reference model state
    int   m_sc, m_fc; // model counters as plain integers

    always #5 clock = ~clock;

    id_ex_stage_reg #(
        .DATA_W (32),
        .RADDR_W(6),
        .ALUOP_W(3),
        .CNT_W  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .imm       (imm),
        .rd1       (rd1),
        .rd2       (rd2),
        .PC        (PC),
        .rd        (rd),
        .brz       (brz),
        .brn       (brn),
        .j         (j),
        .regw      (regw),
        .wai       (wai),
        .memw      (memw),
        .memr      (memr),
        .alusrc    (alusrc),
        .aluop     (aluop),
        .out_valid (out_valid),
        .out_imm   (out_imm),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_PC    (out_PC),
        .out_rd    (out_rd),
        .out_brz   (out_brz),
        .out_brn   (out_brn),
        .out_j     (out_j),
        .out_regw  (out_regw),
        .out_wai   (out_wai),
        .out_memw  (out_memw),
        .out_memr  (out_memr),
        .out_alusrc(out_alusrc),
        .out_aluop (out_aluop),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    task automatic drive(input stim_t s);
        reset = s.rst; stall = s.stl; flush = s.fls; in_valid = s.iv;
        imm = s.imm; rd1 = s.rd1; rd2 = s.rd2; PC = s.pc; rd = s.rd;
        brz = s.brz; brn = s.brn; j = s.j; regw = s.regw; wai = s.wai;
        memw = s.memw; memr = s.memr; alusrc = s.alusrc; aluop = s.aluop;
    endtask

    // One active (falling) edge, then settle away from it before sampling.
    task automatic edge_wait();
        @(negedge clock);
        #2;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.valid = out_valid; o.imm = out_imm; o.rd1 = out_rd1; o.rd2 = out_rd2;
        o.pc = out_PC; o.rd = out_rd; o.brz = out_brz; o.brn = out_brn; o.j = out_j;
        o.regw = out_regw; o.wai = out_wai; o.memw = out_memw; o.memr = out_memr;
        o.alusrc = out_alusrc; o.aluop = out_aluop; o.sc = stall_cnt; o.fc = flush_cnt;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        nvec++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic add_row(input string name, input logic rst, stl, fls, iv,
                           input logic [31:0] i_imm, i_rd1, input logic [5:0] i_rd,
                           input logic i_regw, i_memw, i_j, input logic [2:0] i_alu,
                           input logic ev, input logic [31:0] e_imm, e_rd1,
                           input logic [5:0] e_rd, input logic e_regw, e_memw, e_j,
                           input logic [2:0] e_alu, input int esc, efc);
        vec_t v;
        v.name = name;
        v.s = '0;
        v.s.rst = rst; v.s.stl = stl; v.s.fls = fls; v.s.iv = iv;
        v.s.imm = i_imm; v.s.rd1 = i_rd1; v.s.rd = i_rd;
        v.s.regw = i_regw; v.s.memw = i_memw; v.s.j = i_j; v.s.aluop = i_alu;
        v.e = '0;
        v.e.valid = ev; v.e.imm = e_imm; v.e.rd1 = e_rd1; v.e.rd = e_rd;
        v.e.regw = e_regw; v.e.memw = e_memw; v.e.j = e_j; v.e.aluop = e_alu;
        v.e.sc = 4'(esc); v.e.fc = 4'(efc);
        tbl.push_back(v);
    endtask

    // Reference model: applies the stage rules for one edge.
    task automatic model_step(input stim_t s);
        if (s.rst) begin
            m = '0; m_sc = 0; m_fc = 0;
        end else if (s.fls) begin
            m.valid = 1'b0;
            {m.brz, m.brn, m.j, m.regw, m.wai, m.memw, m.memr, m.alusrc} = '0;
            m.aluop = '0;
            m_fc = (m_fc < 15) ? m_fc + 1 : 15;
        end else if (s.stl) begin
            m_sc = (m_sc < 15) ? m_sc + 1 : 15;
        end else begin
            m.valid = s.iv;
            m.imm = s.imm; m.rd1 = s.rd1; m.rd2 = s.rd2; m.pc = s.pc; m.rd = s.rd;
            m.brz = s.iv & s.brz; m.brn = s.iv & s.brn; m.j = s.iv & s.j;
            m.regw = s.iv & s.regw; m.wai = s.iv & s.wai; m.memw = s.iv & s.memw;
            m.memr = s.iv & s.memr; m.alusrc = s.iv & s.alusrc;
            m.aluop = s.iv ? s.aluop : 3'd0;
        end
        m.sc = 4'(m_sc);
        m.fc = 4'(m_fc);
    endtask

    initial begin
        stim_t s;
        obs_t  e;

        //      name          rst stl fls iv imm           rd1           rd  rg mw j alu
        //                    ev  e_imm         e_rd1         erd er em ej ealu sc fc
        add_row("reset",      1, 0, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 63, 1, 1, 1, 7,
                              0, 32'h0,        32'h0,        0,  0, 0, 0, 0, 0, 0);
        add_row("load",       0, 0, 0, 1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2,
                              1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2, 0, 0);
        add_row("load_next",  0, 0, 0, 1, 32'h20,       32'h0BADF00D, 7,  0, 0, 1, 5,
                              1, 32'h20,       32'h0BADF00D, 7,  0, 0, 1, 5, 0, 0);
        add_row("reload",     0, 0, 0, 1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2,
                              1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2, 0, 0);
        add_row("stall1",     0, 1, 0, 1, 32'h30,       32'hFFFFFFFF, 9,  0, 1, 0, 6,
                              1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2, 1, 0);
        add_row("stall2",     0, 1, 0, 1, 32'h30,       32'hFFFFFFFF, 9,  0, 1, 0, 6,
                              1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2, 2, 0);
        add_row("stall3",     0, 1, 0, 1, 32'h30,       32'hFFFFFFFF, 9,  0, 1, 0, 6,
                              1, 32'h10,       32'h12345678, 5,  1, 0, 0, 2, 3, 0);
        add_row("release",    0, 0, 0, 1, 32'h30,       32'hFFFFFFFF, 9,  0, 1, 0, 6,
                              1, 32'h30,       32'hFFFFFFFF, 9,  0, 1, 0, 6, 3, 0);
        add_row("load_mem",   0, 0, 0, 1, 32'h40,       32'h55AA55AA, 12, 1, 1, 0, 3,
                              1, 32'h40,       32'h55AA55AA, 12, 1, 1, 0, 3, 3, 0);
        add_row("flush_stall",0, 1, 1, 1, 32'h50,       32'h11111111, 13, 1, 1, 0, 1,
                              0, 32'h40,       32'h55AA55AA, 12, 0, 0, 0, 0, 3, 1);
        add_row("bubble",     0, 0, 0, 0, 32'h60,       32'h22222222, 14, 1, 1, 1, 4,
                              0, 32'h60,       32'h22222222, 14, 0, 0, 0, 0, 3, 1);
        add_row("flush",      0, 0, 1, 1, 32'h70,       32'h44444444, 2,  1, 1, 1, 4,
                              0, 32'h60,       32'h22222222, 14, 0, 0, 0, 0, 3, 2);
        add_row("post_flush", 0, 0, 0, 1, 32'h80,       32'h33333333, 15, 1, 0, 1, 7,
                              1, 32'h80,       32'h33333333, 15, 1, 0, 1, 7, 3, 2);
        add_row("reset_busy", 1, 1, 1, 1, 32'h90,       32'h66666666, 1,  1, 1, 1, 1,
                              0, 32'h0,        32'h0,        0,  0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].s);
            edge_wait();
            check(tbl[i].name, tbl[i].e);
        end

        // Stall counter saturation: 20 stalled edges from a cleared stage.
        s = '0;
        s.stl = 1'b1; s.iv = 1'b1; s.imm = 32'hA5A5A5A5; s.regw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(s);
            edge_wait();
            e = '0;
            e.sc = (i + 1 < 15) ? 4'(i + 1) : 4'd15;
            check($sformatf("stall_sat%0d", i), e);
        end
        // Flush counter saturation, stall held too so stall_cnt must stay at 15.
        s.fls = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(s);
            edge_wait();
            e = '0;
            e.sc = 4'd15;
            e.fc = (i + 1 < 15) ? 4'(i + 1) : 4'd15;
            check($sformatf("flush_sat%0d", i), e);
        end
        s = '0;
        s.rst = 1'b1; s.stl = 1'b1;
        drive(s);
        edge_wait();
        check("sat_reset", '0);

        // Randomized run against the reference model.
        m = '0; m_sc = 0; m_fc = 0;
        for (int i = 0; i < 400; i++) begin
            s.rst    = ($urandom_range(0, 99) < 3);
            s.stl    = ($urandom_range(0, 99) < 30);
            s.fls    = ($urandom_range(0, 99) < 12);
            s.iv     = ($urandom_range(0, 99) < 70);
            s.imm    = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.pc = $urandom;
            s.rd     = 6'($urandom);
            {s.brz, s.brn, s.j, s.regw, s.wai, s.memw, s.memr, s.alusrc} = 8'($urandom);
            s.aluop  = 3'($urandom);
            drive(s);
            edge_wait();
            model_step(s);
            check($sformatf("rand%0d", i), m);
            if (!out_valid) begin
                nvec++;
                if ({out_regw, out_memw, out_memr, out_brz, out_brn, out_j} !== 6'b0) begin
                    errors++;
                    $display("FAIL bubble_inv%0d: side-effect bits %b, required 000000", i,
                             {out_regw, out_memw, out_memr, out_brz, out_brn, out_j});
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register carrying decoded operands, PC, destination register and control bits from decode to execute.
- Adds behaviour a plain latch lacks: synchronous reset, a valid bit, and hazard control.
- Stall holds the stage contents; flush converts the stage into a bubble.
- Saturating stall and flush event counters feed the performance/debug readout.

Parameters:
- DATA_W, 32, width of imm, rd1, rd2, PC fields.
- RADDR_W, 6, width of destination register field rd.
- ALUOP_W, 3, width of aluop field.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clock  input  1  stage clock; all state updates on falling edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold current contents (from hazard unit).
- flush  input  1  replace stage contents with a bubble (branch/jump redirect).
- in_valid  input  1  decode stage holds a real instruction.
- imm, rd1, rd2, PC  input  DATA_W each  decode data fields.
- rd  input  RADDR_W  destination register.
- brz, brn, j, regw, wai, memw, memr, alusrc  input  1 each  decode control bits.
- aluop  input  ALUOP_W  ALU operation.
- out_valid  output  1  execute stage holds a real instruction.
- out_imm, out_rd1, out_rd2, out_PC  output  DATA_W  registered data fields.
- out_rd  output  RADDR_W  registered destination.
- out_brz, out_brn, out_j, out_regw, out_wai, out_memw, out_memr, out_alusrc  output  1 each  registered control.
- out_aluop  output  ALUOP_W  registered ALU op.
- stall_cnt  output  CNT_W  falling edges with stall=1 and flush=0, saturating.
- flush_cnt  output  CNT_W  falling edges with flush=1, saturating.

Behaviour:
- Clocking and latency:
  - Single clock, falling-edge triggered.
  - Latency is 1 edge: inputs sampled at falling edge N appear on the outputs after edge N.
- Priority each edge: reset > flush > stall > load.
- Reset:
  - All outputs go to 0, including out_valid, every control bit, every data field, out_aluop and both counters.
  - A reset mid-stall or mid-flush discards the stage contents; counters clear.
- Flush:
  - out_valid=0.
  - All control outputs (brz, brn, j, regw, wai, memw, memr, alusrc) go to 0 and out_aluop goes to 0.
  - Data fields and out_rd are NOT updated; they hold their prior values and are don't-care for consumers while out_valid=0.
  - flush_cnt increments.
  - flush and stall together: flush wins, and stall_cnt does not increment.
- Stall (flush=0):
  - Every output holds its value, including out_valid.
  - stall_cnt increments.
- Load (no reset/flush/stall):
  - Every output takes its input.
  - out_valid=in_valid.
  - If in_valid=0, control outputs and out_aluop are forced to 0 (bubble); data fields still load.
- Invariant: out_valid=0 implies out_regw=out_memw=out_memr=out_brz=out_brn=out_j=0. No side effects leak from a bubble.
- Counters:
  - Unsigned; saturate at all-ones (2^CNT_W-1) with no wrap.
  - Cleared only by reset.
- Widths: all fields pass through unmodified; no sign-extension or arithmetic in this block.
- No combinational input-to-output paths; every output is a register.

Test Plan:
- Reset: drive inputs nonzero, assert reset for 1 falling edge -> every output 0, stall_cnt=0, flush_cnt=0.
- Normal load: in_valid=1, imm=0x0000_0010, rd1=0x1234_5678, rd=6'd5, regw=1, aluop=3'b010 -> after one falling edge out_valid=1 and outputs match the inputs; change inputs -> outputs follow one edge later.
- Stall: after the load above, assert stall for 3 edges with new inputs rd1=0xFFFF_FFFF -> outputs hold 0x1234_5678, out_valid=1, stall_cnt=3; release -> 0xFFFF_FFFF loads on the next edge.
- Flush with stall: load memw=1, regw=1, then assert flush=1 and stall=1 together -> out_valid=0, out_memw=0, out_regw=0, out_aluop=0, out_rd1 unchanged, flush_cnt=1, stall_cnt unchanged.
- Bubble load: in_valid=0 with regw=1, memw=1, j=1 -> out_valid=0, all control outputs 0, out_imm equals input imm.
- Saturation (CNT_W=4): hold stall for 20 edges -> stall_cnt reaches 15 and stays 15; reset -> 0.
